// File: rtl/route_nodes_pkg.sv
// Shared constants and crosspoint indexing for the route_nodes routing tile.
// Pure definitions: no timing or flow control.
package route_nodes_pkg;

  localparam int V_DEF = 8;
  localparam int H_DEF = 4;

  // Bit j*V+i of the configuration word joins vertical i with horizontal j.
  function automatic int cfg_idx(input int i, input int j, input int nv);
    return j * nv + i;
  endfunction

endpackage

// File: rtl/route_nodes_if.sv
// Programming and track bundle for route_nodes; master is the driver, slave is the tile.
// No handshake: prog_we is a single-cycle load strobe and tracks are level signals.
interface route_nodes_if
  import route_nodes_pkg::*;
#(
  parameter int V = V_DEF,
  parameter int H = H_DEF
);

  logic             prog_we;
  logic [V*H-1:0]   prog_i;
  logic [V*H-1:0]   prog_o;
  logic [V-1:0]     v_i;
  logic [V-1:0]     v_o;
  logic [H-1:0]     h_i;
  logic [H-1:0]     h_o;
  logic [V-1:0]     y_o;
  logic [V-1:0]     b_o;

  modport master (
    output prog_we, prog_i, v_i, h_i,
    input  prog_o, v_o, h_o, y_o, b_o
  );

  modport slave (
    input  prog_we, prog_i, v_i, h_i,
    output prog_o, v_o, h_o, y_o, b_o
  );

endinterface

// File: rtl/route_xpoint.sv
// One programmable crosspoint: gates each crossing track into the other when enabled.
// Combinational, no state, no backpressure.
module route_xpoint (
  input  logic en,
  input  logic v,
  input  logic h,
  output logic v_x,
  output logic h_x
);

  assign v_x = en & h;
  assign h_x = en & v;

endmodule

// File: rtl/route_nodes.sv
// Routing tile: config register driving an X crosspoint matrix, Y tap nodes and V buffers.
// Routing is combinational, or 1-cycle registered with ROUTE_NODES_OUT_REG_EN; no backpressure.
module route_nodes
  import route_nodes_pkg::*;
#(
  parameter int V = V_DEF,
  parameter int H = H_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  route_nodes_if.slave   bus
);

  logic [V*H-1:0]         cfg;
  logic [V-1:0][H-1:0]    vx;
  logic [H-1:0][V-1:0]    hx;
  logic [V-1:0]           v_n;
  logic [H-1:0]           h_n;
  logic [V-1:0]           y_n;
  logic [V-1:0]           b_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (bus.prog_we) begin
      cfg <= bus.prog_i;
    end
  end

  assign bus.prog_o = cfg;

  // Cross terms use only the *_i inputs, so the matrix can never form a loop.
  for (genvar i = 0; i < V; i++) begin : g_vert
    for (genvar j = 0; j < H; j++) begin : g_horz
      localparam int K = cfg_idx(i, j, V);
      route_xpoint u_xp (
        .en  (cfg[K]),
        .v   (bus.v_i[i]),
        .h   (bus.h_i[j]),
        .v_x (vx[i][j]),
        .h_x (hx[j][i])
      );
    end
    assign v_n[i] = bus.v_i[i] | (|vx[i]);
  end

  for (genvar j = 0; j < H; j++) begin : g_hsum
    assign h_n[j] = bus.h_i[j] | (|hx[j]);
  end

  assign y_n = bus.v_i & cfg[V-1:0];
  assign b_n = bus.v_i;

`ifdef ROUTE_NODES_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.v_o <= '0;
      bus.h_o <= '0;
      bus.y_o <= '0;
      bus.b_o <= '0;
    end else begin
      bus.v_o <= v_n;
      bus.h_o <= h_n;
      bus.y_o <= y_n;
      bus.b_o <= b_n;
    end
  end
`else
  assign bus.v_o = v_n;
  assign bus.h_o = h_n;
  assign bus.y_o = y_n;
  assign bus.b_o = b_n;
`endif

endmodule

// File: tb/tb_route_nodes.sv
// Directed bench for route_nodes (V=8, H=4) covering both output-register builds.
module tb_route_nodes;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  route_nodes_if #(.V(8), .H(4)) bus ();

  route_nodes #(.V(8), .H(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ROUTE_NODES_OUT_REG_EN
  localparam logic [3:0] RST_H = 4'h0;
`else
  localparam logic [3:0] RST_H = 4'hF;
`endif

  // Let routing outputs reflect the current inputs and cfg.
  task automatic settle();
`ifdef ROUTE_NODES_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic load_cfg(input logic [31:0] w);
    @(negedge clk);
    bus.prog_i  = w;
    bus.prog_we = 1'b1;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_i  = '0;
    bus.h_i     = 4'hF;
    bus.v_i     = 8'h00;
    settle();
    n_cmp++; if (bus.h_o !== RST_H) begin n_err++; $display("FAIL rst_h_o actual=%h required=%h", bus.h_o, RST_H); end
    n_cmp++; if (bus.v_o !== 8'h00) begin n_err++; $display("FAIL rst_v_o actual=%h required=00", bus.v_o); end
    n_cmp++; if (bus.y_o !== 8'h00) begin n_err++; $display("FAIL rst_y_o actual=%h required=00", bus.y_o); end
    n_cmp++; if (bus.b_o !== 8'h00) begin n_err++; $display("FAIL rst_b_o actual=%h required=00", bus.b_o); end
    n_cmp++; if (bus.prog_o !== 32'h0) begin n_err++; $display("FAIL rst_prog_o actual=%h required=00000000", bus.prog_o); end
    // Load strobe during reset must be ignored.
    @(negedge clk);
    bus.prog_i  = 32'hFFFF_FFFF;
    bus.prog_we = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.prog_o !== 32'h0) begin n_err++; $display("FAIL rst_vs_we actual=%h required=00000000", bus.prog_o); end
    bus.prog_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_diag();
    load_cfg(32'h0804_0201);
    n_cmp++; if (bus.prog_o !== 32'h0804_0201) begin n_err++; $display("FAIL load_prog_o actual=%h required=08040201", bus.prog_o); end
    // Hold: prog_i changes without the strobe must not reach cfg.
    bus.prog_i = 32'h1234_5678;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.prog_o !== 32'h0804_0201) begin n_err++; $display("FAIL hold_prog_o actual=%h required=08040201", bus.prog_o); end

    bus.h_i = 4'hF; bus.v_i = 8'h00;
    settle();
    n_cmp++; if (bus.v_o !== 8'h0F) begin n_err++; $display("FAIL diag_h_v_o actual=%h required=0f", bus.v_o); end
    n_cmp++; if (bus.h_o !== 4'hF) begin n_err++; $display("FAIL diag_h_h_o actual=%h required=f", bus.h_o); end
    n_cmp++; if (bus.y_o !== 8'h00) begin n_err++; $display("FAIL diag_h_y_o actual=%h required=00", bus.y_o); end

    bus.h_i = 4'h0; bus.v_i = 8'h02;
    settle();
    n_cmp++; if (bus.h_o !== 4'h2) begin n_err++; $display("FAIL diag_v2_h_o actual=%h required=2", bus.h_o); end
    n_cmp++; if (bus.v_o !== 8'h02) begin n_err++; $display("FAIL diag_v2_v_o actual=%h required=02", bus.v_o); end
    n_cmp++; if (bus.y_o !== 8'h00) begin n_err++; $display("FAIL diag_v2_y_o actual=%h required=00", bus.y_o); end
    n_cmp++; if (bus.b_o !== 8'h02) begin n_err++; $display("FAIL diag_v2_b_o actual=%h required=02", bus.b_o); end

    bus.v_i = 8'hFF;
    settle();
    n_cmp++; if (bus.v_o !== 8'hFF) begin n_err++; $display("FAIL diag_vff_v_o actual=%h required=ff", bus.v_o); end
    n_cmp++; if (bus.h_o !== 4'hF) begin n_err++; $display("FAIL diag_vff_h_o actual=%h required=f", bus.h_o); end
    n_cmp++; if (bus.y_o !== 8'h01) begin n_err++; $display("FAIL diag_vff_y_o actual=%h required=01", bus.y_o); end
    n_cmp++; if (bus.b_o !== 8'hFF) begin n_err++; $display("FAIL diag_vff_b_o actual=%h required=ff", bus.b_o); end
  endtask

  task automatic test_all_ones();
    load_cfg(32'hFFFF_FFFF);
    bus.h_i = 4'h1; bus.v_i = 8'h00;
    settle();
    n_cmp++; if (bus.v_o !== 8'hFF) begin n_err++; $display("FAIL ones_v_o actual=%h required=ff", bus.v_o); end
    n_cmp++; if (bus.h_o !== 4'h1) begin n_err++; $display("FAIL ones_h_o actual=%h required=1", bus.h_o); end
    n_cmp++; if (bus.y_o !== 8'h00) begin n_err++; $display("FAIL ones_y_o actual=%h required=00", bus.y_o); end

    bus.h_i = 4'h0; bus.v_i = 8'h80;
    settle();
    n_cmp++; if (bus.h_o !== 4'hF) begin n_err++; $display("FAIL ones_v80_h_o actual=%h required=f", bus.h_o); end
    n_cmp++; if (bus.v_o !== 8'h80) begin n_err++; $display("FAIL ones_v80_v_o actual=%h required=80", bus.v_o); end
    n_cmp++; if (bus.y_o !== 8'h80) begin n_err++; $display("FAIL ones_v80_y_o actual=%h required=80", bus.y_o); end
  endtask

  task automatic test_async_reset();
    load_cfg(32'hFFFF_FFFF);
    bus.h_i = 4'h1; bus.v_i = 8'h00;
    settle();
    n_cmp++; if (bus.v_o !== 8'hFF) begin n_err++; $display("FAIL pre_arst_v_o actual=%h required=ff", bus.v_o); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.prog_o !== 32'h0) begin n_err++; $display("FAIL arst_prog_o actual=%h required=00000000", bus.prog_o); end
    n_cmp++; if (bus.v_o !== 8'h00) begin n_err++; $display("FAIL arst_v_o actual=%h required=00", bus.v_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ROUTE_NODES_OUT_REG_EN
  task automatic test_out_reg();
    load_cfg(32'h0804_0201);
    bus.h_i = 4'h0; bus.v_i = 8'h00;
    settle();
    @(negedge clk);
    bus.v_i = 8'hFF;
    #1;
    n_cmp++; if (bus.v_o !== 8'h00) begin n_err++; $display("FAIL reg_pre_v_o actual=%h required=00", bus.v_o); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.v_o !== 8'hFF) begin n_err++; $display("FAIL reg_v_o actual=%h required=ff", bus.v_o); end
    n_cmp++; if (bus.h_o !== 4'hF) begin n_err++; $display("FAIL reg_h_o actual=%h required=f", bus.h_o); end
    n_cmp++; if (bus.y_o !== 8'h01) begin n_err++; $display("FAIL reg_y_o actual=%h required=01", bus.y_o); end
    n_cmp++; if (bus.b_o !== 8'hFF) begin n_err++; $display("FAIL reg_b_o actual=%h required=ff", bus.b_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.v_o, bus.h_o, bus.y_o, bus.b_o} !== 28'h0) begin n_err++; $display("FAIL reg_rst_outs actual=%h required=0000000", {bus.v_o, bus.h_o, bus.y_o, bus.b_o}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_diag();
    test_all_ones();
    test_async_reset();
`ifdef ROUTE_NODES_OUT_REG_EN
    test_out_reg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/route_nodes.md
Name: route_nodes

Overview:
- Programmable routing-node tile for the eFPGA interconnect.
- Holds a configuration register and drives three node types from it:
  - X crosspoint matrix joining V vertical and H horizontal tracks.
  - Y tap nodes on the vertical tracks.
  - V plain buffer nodes on the vertical tracks.
- Sits between logic tiles; a configuration controller loads its programming word.

Parameters:
- V, 8, number of vertical tracks.
- H, 4, number of horizontal tracks.

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- prog_we  input  1  load strobe for the configuration register.
- prog_i  input  V*H  configuration word to load.
- prog_o  output  V*H  current configuration-register contents (readback).
- v_i  input  V  vertical tracks entering from north.
- v_o  output  V  vertical tracks leaving south (X matrix).
- h_i  input  H  horizontal tracks entering from west.
- h_o  output  H  horizontal tracks leaving east (X matrix).
- y_o  output  V  Y-node outputs.
- b_o  output  V  V-node (buffer) outputs.

Behaviour:
- Configuration register cfg[V*H-1:0]:
  - Asynchronously cleared to 0 while rst_n=0.
  - On rising clk with prog_we=1, cfg <= prog_i; otherwise it holds.
  - prog_o = cfg.
  - A new configuration takes effect on routing from the cycle after the load edge.
- Crosspoint indexing: bit cfg[j*V+i] connects vertical i to horizontal j (i in 0..V-1, j in 0..H-1).
- X matrix, combinational:
  - v_o[i] = v_i[i] OR (OR over j of cfg[j*V+i] AND h_i[j]).
  - h_o[j] = h_i[j] OR (OR over i of cfg[j*V+i] AND v_i[i]).
  - Tracks always pass straight through; a set crosspoint additionally ORs the crossing track in.
  - No combinational loop: only *_i inputs feed the cross terms.
- Y nodes: y_o[i] = v_i[i] AND cfg[i], using the low V bits of cfg only.
- V nodes: b_o = v_i, unconditional.
- Reset values:
  - cfg=0 → v_o=v_i, h_o=h_i, y_o=0, b_o=v_i, prog_o=0.
  - Reset asserted mid-operation clears all crosspoints immediately (asynchronous).
- Simultaneous rst_n=0 and prog_we=1: reset wins.
- Multiple crosspoints on one track OR together; all-ones cfg connects every horizontal to every vertical.

Optional Feature:
- Macro: ROUTE_NODES_OUT_REG_EN.
- Defined:
  - v_o, h_o, y_o and b_o are registered on rising clk, giving 1-cycle latency from v_i/h_i/cfg.
  - These registers are asynchronously reset to 0 by rst_n.
  - prog_o stays unregistered (it is cfg directly).
- Undefined:
  - All routing outputs are purely combinational (0-cycle latency).
  - Reset values are as listed under Behaviour.

Decomposition:
- Package route_nodes_pkg holds:
  - Default constants V_DEF=8 and H_DEF=4.
  - A function cfg_idx(i,j) returning j*V+i.
- One natural sub-module: route_xpoint.
  - Single crosspoint with ports en, v, h, v_x, h_x.
  - v_x = en AND h; h_x = en AND v.
  - Instantiated V*H times in a generate loop.
  - The parent OR-reduces the v_x/h_x contributions per track.

Test Plan (combinational build, V=8, H=4):
- Reset, prog=0, h_i=4'hF, v_i=8'h00 → h_o=4'hF, v_o=8'h00, y_o=8'h00, b_o=8'h00, prog_o=0.
- prog_we pulse with prog_i=32'h08040201, then h_i=4'hF, v_i=0 → v_o=8'h0F, h_o=4'hF, y_o=8'h00.
- Same cfg, h_i=0, v_i=8'h02 → h_o=4'h2, v_o=8'h02, y_o=8'h00, b_o=8'h02.
- Same cfg, v_i=8'hFF, h_i=0 → v_o=8'hFF, h_o=4'hF, y_o=8'h01, b_o=8'hFF.
- Load prog_i=32'hFFFFFFFF, h_i=4'h1, v_i=0 → v_o=8'hFF, h_o=4'h1.
  - Then assert rst_n=0 mid-cycle → prog_o=0 and v_o=8'h00 without waiting for a clk edge.
- With ROUTE_NODES_OUT_REG_EN defined, cfg 32'h08040201 and v_i stepped 0→8'hFF:
  - Outputs change one clk edge later: v_o=8'hFF, h_o=4'hF, y_o=8'h01, b_o=8'hFF.
  - Under reset all four outputs read 0.
